alu_issue_ctrl: RTL and testbench
=================================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on posedge clk.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-low reset, acting on negedge rst.
REQ-003 SHALL have port instr_valid, input, 1 bit: instruction word offered.
REQ-004 SHALL have port instr_ready, output, 1 bit: block can accept an instruction.
REQ-005 SHALL have port instr, input, 16 bits: op[15:13], rd[12:10], rs1[9:7], rs2[6:4]; bits [3:0] reserved and ignored.
REQ-006 SHALL have port alu_in1, output, 16 bits: registered operand A to the ALU.
REQ-007 SHALL have port alu_in2, output, 16 bits: registered operand B to the ALU.
REQ-008 SHALL have port alu_sel, output, 3 bits: registered ALU op (0 add, 1 sub, 2 and, 3 or, 4 not in1, 5 xor, 6 pass in2, 7 add).
REQ-009 SHALL have port alu_out, input, 16 bits: combinational ALU result.
REQ-010 SHALL have port alu_zf, input, 1 bit: ALU zero flag, registered one clock after alu_out.
REQ-011 SHALL have port wb_valid, output, 1 bit: one-cycle writeback pulse.
REQ-012 SHALL have port wb_addr, output, 3 bits: destination register of the writeback.
REQ-013 SHALL have port wb_data, output, 16 bits: result written back.
REQ-014 SHALL have port zero_flag, output, 1 bit: alu_zf of the last completed instruction.
REQ-015 SHALL have port dbg_addr, input, 3 bits: debug read address.
REQ-016 SHALL have port dbg_data, output, 16 bits: combinational read of register dbg_addr.

Function
REQ-017 SHALL hold an 8x16 register file; r0 SHALL always read 0, and writes to r0 SHALL be discarded.
REQ-018 SHALL implement FSM states IDLE -> ISSUE -> SETTLE -> IDLE; instr_ready SHALL be 1 only in IDLE.
REQ-019 SHALL accept an instruction at edge N when state is IDLE and instr_valid is 1; instr is ignored at all other times.
REQ-020 At edge N, SHALL load alu_in1 = R[rs1], alu_in2 = R[rs2] and alu_sel = op, and enter ISSUE.
REQ-021 At edge N+1, SHALL capture alu_out into result_q and enter SETTLE; the ALU's zf becomes valid in this cycle.
REQ-022 At edge N+2, SHALL write R[rd] = result_q, set zero_flag = alu_zf, set wb_valid = 1 with wb_addr = rd and wb_data = result_q, and enter IDLE.
REQ-023 SHALL clear wb_valid at the next edge; wb_addr/wb_data SHALL hold their values until the next writeback.
REQ-024 Earliest next acceptance SHALL be edge N+3; throughput is one instruction per 3 clocks.
REQ-025 An instruction accepted at edge N+3 SHALL read the register value written at edge N+2 (no hazard).
REQ-026 All arithmetic SHALL be modulo 2^16, performed by the ALU; the block adds no carry or overflow.
REQ-027 alu_in1, alu_in2 and alu_sel SHALL hold their values outside ISSUE.

Reset
REQ-028 On rst low, SHALL immediately set state IDLE, registers R0..R7 = 0, alu_in1 = alu_in2 = 0, alu_sel = 0, result_q = 0, wb_valid = 0, wb_addr = 0, wb_data = 0 and zero_flag = 0.
REQ-029 Reset in ISSUE or SETTLE SHALL abort the instruction with no writeback; instr_ready = 1 in the first cycle after release.

Configuration
REQ-030 With ALU_ISSUE_IMM_EN defined, op 6 SHALL drive alu_in2 = zero-extended instr[6:0] (move immediate).
REQ-031 With ALU_ISSUE_IMM_EN undefined, op 6 SHALL drive alu_in2 = R[rs2], the same as every other op.

Structure
REQ-032 Package alu_pkg SHALL hold the opcode constants OP_ADD..OP_PASS, the FSM state encoding, the data width (16) and the register-address width (3).
REQ-033 The register file SHALL be sub-module alu_regfile, with 2 combinational read ports, 1 debug read port and 1 synchronous write port with async reset.

Verification
REQ-034 After reset, issue NOT r1 (op 4, rs1 = 0) at edge N -> wb_valid high after edge N+2, wb_data = 0xFFFF, zero_flag = 0, dbg r1 = 0xFFFF.
REQ-035 Issue ADD r2 = r1 + r1 -> r2 = 0xFFFE; then SUB r3 = r1 - r1 -> wb_data = 0x0000, zero_flag = 1.
REQ-036 Issue NOT into rd = 0 -> wb_addr = 0, wb_data = 0xFFFF, dbg r0 reads 0x0000.
REQ-037 Hold instr_valid high with two instructions back to back -> instr_ready low in ISSUE/SETTLE, second accepted at edge N+3, second reads the first's result.
REQ-038 Assert rst during SETTLE -> no wb_valid, all registers 0, zero_flag 0, instr_ready 1 after release.
REQ-039 With ALU_ISSUE_IMM_EN defined, op 6, rd = 5, instr[6:0] = 0x55 -> R5 = 0x0055, zero_flag = 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue controller: widths, ALU opcodes and FSM encoding.
package alu_pkg;

   localparam int DATA_W   = 16;
   localparam int REG_AW   = 3;
   localparam int NUM_REGS = 1 << REG_AW;

   typedef enum logic [2:0] {
      OP_ADD  = 3'd0,
      OP_SUB  = 3'd1,
      OP_AND  = 3'd2,
      OP_OR   = 3'd3,
      OP_NOT  = 3'd4,
      OP_XOR  = 3'd5,
      OP_PASS = 3'd6,
      OP_ADD2 = 3'd7
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_SETTLE = 2'd2
   } state_e;

endpackage

// File: rtl/alu_regfile.sv
// 8x16 register file: two operand read ports, one debug read port, one write port.
// r0 is hardwired to zero; writes addressed to it are dropped.
module alu_regfile
   import alu_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] ra1_i,
   input  logic [REG_AW-1:0] ra2_i,
   input  logic [REG_AW-1:0] dbg_ra_i,
   output logic [DATA_W-1:0] rd1_o,
   output logic [DATA_W-1:0] rd2_o,
   output logic [DATA_W-1:0] dbg_rd_o,
   input  logic              we_i,
   input  logic [REG_AW-1:0] wa_i,
   input  logic [DATA_W-1:0] wd_i
);

   logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         regs_q <= '0;
      end else if (we_i && (wa_i != '0)) begin
         regs_q[wa_i] <= wd_i;
      end
   end

   assign rd1_o    = (ra1_i    == '0) ? '0 : regs_q[ra1_i];
   assign rd2_o    = (ra2_i    == '0) ? '0 : regs_q[ra2_i];
   assign dbg_rd_o = (dbg_ra_i == '0) ? '0 : regs_q[dbg_ra_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Three-cycle issue/settle/writeback controller around an external combinational ALU.
// Optional ALU_ISSUE_IMM_EN: op 6 takes a zero-extended 7-bit immediate as operand B.
module alu_issue_ctrl
   import alu_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [15:0]       instr,
   output logic [DATA_W-1:0] alu_in1,
   output logic [DATA_W-1:0] alu_in2,
   output logic [2:0]        alu_sel,
   input  logic [DATA_W-1:0] alu_out,
   input  logic              alu_zf,
   output logic              wb_valid,
   output logic [REG_AW-1:0] wb_addr,
   output logic [DATA_W-1:0] wb_data,
   output logic              zero_flag,
   input  logic [REG_AW-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   state_e state_q, state_d;
   logic   accept, capture, commit;

   logic [2:0]        op;
   logic [REG_AW-1:0] rd, rs1, rs2;
   logic [DATA_W-1:0] rs1_data, rs2_data, opb;

   logic [DATA_W-1:0] alu_in1_q, alu_in2_q, result_q, wb_data_q;
   logic [2:0]        alu_sel_q;
   logic [REG_AW-1:0] rd_q, wb_addr_q;
   logic              wb_valid_q, zero_flag_q;

   logic unused_rsvd;

   assign op          = instr[15:13];
   assign rd          = instr[12:10];
   assign rs1         = instr[9:7];
   assign rs2         = instr[6:4];
   assign unused_rsvd = ^instr[3:0];

   alu_regfile u_regfile (
      .clk      (clk),
      .rst      (rst),
      .ra1_i    (rs1),
      .ra2_i    (rs2),
      .dbg_ra_i (dbg_addr),
      .rd1_o    (rs1_data),
      .rd2_o    (rs2_data),
      .dbg_rd_o (dbg_data),
      .we_i     (commit),
      .wa_i     (rd_q),
      .wd_i     (result_q)
   );

`ifdef ALU_ISSUE_IMM_EN
   assign opb = (op == OP_PASS) ? {{(DATA_W-7){1'b0}}, instr[6:0]} : rs2_data;
`else
   assign opb = rs2_data;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      capture = 1'b0;
      commit  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (instr_valid) begin
               accept  = 1'b1;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            capture = 1'b1;
            state_d = ST_SETTLE;
         end
         ST_SETTLE: begin
            commit  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Operand registers only move on acceptance, so the ALU inputs are stable through SETTLE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         alu_in1_q   <= '0;
         alu_in2_q   <= '0;
         alu_sel_q   <= '0;
         rd_q        <= '0;
         result_q    <= '0;
         wb_valid_q  <= 1'b0;
         wb_addr_q   <= '0;
         wb_data_q   <= '0;
         zero_flag_q <= 1'b0;
      end else begin
         wb_valid_q <= commit;
         if (accept) begin
            alu_in1_q <= rs1_data;
            alu_in2_q <= opb;
            alu_sel_q <= op;
            rd_q      <= rd;
         end
         if (capture) result_q <= alu_out;
         if (commit) begin
            wb_addr_q   <= rd_q;
            wb_data_q   <= result_q;
            zero_flag_q <= alu_zf;
         end
      end
   end

   assign instr_ready = (state_q == ST_IDLE);
   assign alu_in1     = alu_in1_q;
   assign alu_in2     = alu_in2_q;
   assign alu_sel     = alu_sel_q;
   assign wb_valid    = wb_valid_q;
   assign wb_addr     = wb_addr_q;
   assign wb_data     = wb_data_q;
   assign zero_flag   = zero_flag_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: behavioural ALU, register-file model and randomized traffic.
module tb_alu_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [15:0] instr = '0;
   logic [15:0] alu_in1, alu_in2, alu_out, wb_data, dbg_data;
   logic [2:0]  alu_sel, wb_addr, dbg_addr;
   logic        alu_zf, wb_valid, zero_flag;

   int n_cmp = 0;
   int n_bad = 0;

   logic [15:0] mR [8];

   always #5 clk = ~clk;

   alu_issue_ctrl dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_sel(alu_sel),
      .alu_out(alu_out), .alu_zf(alu_zf), .wb_valid(wb_valid), .wb_addr(wb_addr),
      .wb_data(wb_data), .zero_flag(zero_flag), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   function automatic logic [15:0] ref_alu(input logic [2:0] s, input logic [15:0] a, input logic [15:0] b);
      case (s)
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return ~a;
         3'd5:    return a ^ b;
         3'd6:    return b;
         default: return a + b;
      endcase
   endfunction

   // ALU environment: combinational result, zero flag registered one clock later.
   always_comb alu_out = ref_alu(alu_sel, alu_in1, alu_in2);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) alu_zf <= 1'b0;
      else      alu_zf <= (alu_out == 16'h0);
   end

   function automatic logic [15:0] mk(input int op, input int rd, input int rs1, input int rs2);
      return {op[2:0], rd[2:0], rs1[2:0], rs2[2:0], 4'h0};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) mR[i] = 16'h0;
   endtask

   // Issues one instruction from IDLE and checks it against the architectural model.
   task automatic run_instr(input logic [15:0] iw);
      logic [2:0]  op, rd, rs1, rs2;
      logic [15:0] a, b, res;
      int cyc;
      op = iw[15:13]; rd = iw[12:10]; rs1 = iw[9:7]; rs2 = iw[6:4];
      a = mR[rs1]; b = mR[rs2];
`ifdef ALU_ISSUE_IMM_EN
      if (op == 3'd6) b = {9'd0, iw[6:0]};
`endif
      res = ref_alu(op, a, b);
      cyc = 0;
      while (instr_ready !== 1'b1 && cyc < 8) begin @(negedge clk); cyc++; end
      n_cmp++;
      if (instr_ready !== 1'b1) begin n_bad++; $display("FAIL ready_timeout got=%b want=1", instr_ready); end
      instr_valid = 1'b1; instr = iw;
      @(posedge clk); #1;
      instr_valid = 1'b0; instr = 16'($urandom);
      n_cmp++;
      if (instr_ready !== 1'b0 || alu_in1 !== a || alu_in2 !== b || alu_sel !== op) begin
         n_bad++;
         $display("FAIL issue_operands ready=%b in1=%h in2=%h sel=%0d want ready=0 in1=%h in2=%h sel=%0d",
                  instr_ready, alu_in1, alu_in2, alu_sel, a, b, op);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (instr_ready !== 1'b0 || wb_valid !== 1'b0) begin
         n_bad++; $display("FAIL settle_state ready=%b wb_valid=%b want 0/0", instr_ready, wb_valid);
      end
      @(posedge clk); #1;
      if (rd != 3'd0) mR[rd] = res;
      dbg_addr = rd; #1;
      n_cmp++;
      if (wb_valid !== 1'b1 || wb_addr !== rd || wb_data !== res || zero_flag !== (res == 16'h0) ||
          instr_ready !== 1'b1 || dbg_data !== mR[rd] || alu_in1 !== a || alu_in2 !== b || alu_sel !== op) begin
         n_bad++;
         $display("FAIL writeback vld=%b addr=%0d data=%h zf=%b rdy=%b dbg=%h in1=%h want 1/%0d/%h/%b/1/%h/%h",
                  wb_valid, wb_addr, wb_data, zero_flag, instr_ready, dbg_data, alu_in1,
                  rd, res, (res == 16'h0), mR[rd], a);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (wb_valid !== 1'b0 || wb_addr !== rd || wb_data !== res) begin
         n_bad++; $display("FAIL wb_hold vld=%b addr=%0d data=%h want 0/%0d/%h", wb_valid, wb_addr, wb_data, rd, res);
      end
   endtask

   task automatic test_reset();
      model_reset();
      rst = 1'b0; instr_valid = 1'b0; dbg_addr = '0;
      repeat (3) @(posedge clk);
      @(negedge clk); rst = 1'b1; #1;
      n_cmp++;
      if (instr_ready !== 1'b1 || wb_valid !== 1'b0 || wb_addr !== 3'd0 || wb_data !== 16'h0 ||
          zero_flag !== 1'b0 || alu_in1 !== 16'h0 || alu_in2 !== 16'h0 || alu_sel !== 3'd0) begin
         n_bad++;
         $display("FAIL reset_outputs rdy=%b vld=%b addr=%0d data=%h zf=%b in1=%h in2=%h sel=%0d want all zero, rdy=1",
                  instr_ready, wb_valid, wb_addr, wb_data, zero_flag, alu_in1, alu_in2, alu_sel);
      end
      for (int i = 0; i < 8; i++) begin
         dbg_addr = 3'(i); #1;
         n_cmp++;
         if (dbg_data !== 16'h0) begin n_bad++; $display("FAIL reset_reg r%0d got=%h want=0000", i, dbg_data); end
      end
   endtask

   task automatic test_directed();
      run_instr(mk(4, 1, 0, 0));
      dbg_addr = 3'd1; #1;
      n_cmp++;
      if (dbg_data !== 16'hFFFF || zero_flag !== 1'b0) begin
         n_bad++; $display("FAIL not_r1 dbg=%h zf=%b want FFFF/0", dbg_data, zero_flag);
      end
      run_instr(mk(0, 2, 1, 1));
      dbg_addr = 3'd2; #1;
      n_cmp++;
      if (dbg_data !== 16'hFFFE) begin n_bad++; $display("FAIL add_r2 got=%h want=FFFE", dbg_data); end
      run_instr(mk(1, 3, 1, 1));
      n_cmp++;
      if (wb_data !== 16'h0000 || zero_flag !== 1'b1) begin
         n_bad++; $display("FAIL sub_zero data=%h zf=%b want 0000/1", wb_data, zero_flag);
      end
      run_instr(mk(4, 0, 0, 0));
      dbg_addr = 3'd0; #1;
      n_cmp++;
      if (wb_addr !== 3'd0 || wb_data !== 16'hFFFF || dbg_data !== 16'h0000) begin
         n_bad++; $display("FAIL write_r0 addr=%0d data=%h dbg=%h want 0/FFFF/0000", wb_addr, wb_data, dbg_data);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] a_res, b_res;
      @(negedge clk);
      a_res = mR[1] ^ mR[2];
      b_res = a_res + mR[1];
      instr_valid = 1'b1; instr = mk(5, 6, 1, 2);
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
         instr = mk(4, 7, 0, 0);
         n_cmp++;
         if (instr_ready !== 1'b0 || wb_valid !== 1'b0) begin
            n_bad++; $display("FAIL b2b_busy step=%0d rdy=%b vld=%b want 0/0", k, instr_ready, wb_valid);
         end
         @(posedge clk); #1;
      end
      instr = mk(0, 7, 6, 1);
      mR[6] = a_res;
      n_cmp++;
      if (instr_ready !== 1'b1 || wb_valid !== 1'b1 || wb_addr !== 3'd6 || wb_data !== a_res) begin
         n_bad++; $display("FAIL b2b_first rdy=%b vld=%b addr=%0d data=%h want 1/1/6/%h",
                           instr_ready, wb_valid, wb_addr, wb_data, a_res);
      end
      @(posedge clk); #1;
      instr_valid = 1'b0;
      n_cmp++;
      if (instr_ready !== 1'b0 || alu_in1 !== a_res || alu_sel !== 3'd0) begin
         n_bad++; $display("FAIL b2b_second_accept rdy=%b in1=%h sel=%0d want 0/%h/0", instr_ready, alu_in1, alu_sel, a_res);
      end
      repeat (2) @(posedge clk); #1;
      mR[7] = b_res;
      n_cmp++;
      if (wb_valid !== 1'b1 || wb_addr !== 3'd7 || wb_data !== b_res) begin
         n_bad++; $display("FAIL b2b_second_wb vld=%b addr=%0d data=%h want 1/7/%h", wb_valid, wb_addr, wb_data, b_res);
      end
      @(negedge clk);
   endtask

   task automatic test_random();
      for (int n = 0; n < 60; n++) begin
         int gap;
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) begin
            @(negedge clk); instr = 16'($urandom);
         end
         run_instr(16'($urandom));
      end
      for (int i = 0; i < 8; i++) begin
         dbg_addr = 3'(i); #1;
         n_cmp++;
         if (dbg_data !== mR[i]) begin n_bad++; $display("FAIL random_final r%0d got=%h want=%h", i, dbg_data, mR[i]); end
      end
   endtask

   task automatic test_reset_settle();
      @(negedge clk);
      instr_valid = 1'b1; instr = mk(3, 4, 1, 2);
      @(posedge clk); #1;
      instr_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0; #1;
      model_reset();
      n_cmp++;
      if (wb_valid !== 1'b0 || zero_flag !== 1'b0 || instr_ready !== 1'b1 || alu_in1 !== 16'h0 || wb_data !== 16'h0) begin
         n_bad++; $display("FAIL reset_in_settle vld=%b zf=%b rdy=%b in1=%h data=%h want 0/0/1/0/0",
                           wb_valid, zero_flag, instr_ready, alu_in1, wb_data);
      end
      @(negedge clk); rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (wb_valid !== 1'b0 || instr_ready !== 1'b1) begin
            n_bad++; $display("FAIL post_reset cyc=%0d vld=%b rdy=%b want 0/1", k, wb_valid, instr_ready);
         end
      end
      for (int i = 0; i < 8; i++) begin
         dbg_addr = 3'(i); #1;
         n_cmp++;
         if (dbg_data !== 16'h0) begin n_bad++; $display("FAIL reset_settle_reg r%0d got=%h want=0000", i, dbg_data); end
      end
   endtask

`ifdef ALU_ISSUE_IMM_EN
   task automatic test_imm();
      @(negedge clk);
      run_instr({3'd6, 3'd5, 3'd0, 7'h55});
      dbg_addr = 3'd5; #1;
      n_cmp++;
      if (dbg_data !== 16'h0055 || zero_flag !== 1'b0) begin
         n_bad++; $display("FAIL imm_move dbg=%h zf=%b want 0055/0", dbg_data, zero_flag);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_random();
      test_reset_settle();
`ifdef ALU_ISSUE_IMM_EN
      test_imm();
`endif
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

endmodule
